// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM generator.
// One shared period counter drives CHANNELS pulse outputs. Each channel holds a
// written target width and an active width; the active width is only refreshed
// at the period boundary so a pulse is never cut short or stretched mid-period.
// Optional feature: define SERVO_PWM_SLEW_EN to limit the active-width change
// per period to SLEW_STEP cycles (otherwise active width jumps to target).
module servo_pwm_multi #(
   parameter int CHANNELS      = 4,
   parameter int PERIOD_CYCLES = 1_000_000,
   parameter int MIN_PULSE     = 25_000,
   parameter int MAX_PULSE     = 125_000,
   parameter int POS_W         = 8,
   parameter int SLEW_STEP     = 1_000,
   localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [POS_W-1:0]    wr_pos,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start,
   output logic [CHANNELS-1:0] settled
);

   localparam int W  = $clog2(PERIOD_CYCLES);
   localparam int PW = W + POS_W;

   localparam logic [W-1:0]  LAST_CNT = W'(PERIOD_CYCLES - 1);
   localparam logic [W-1:0]  MIN_W    = W'(MIN_PULSE);
   localparam logic [W-1:0]  CENTER_W = W'(MIN_PULSE + ((MAX_PULSE - MIN_PULSE) >> 1));
   localparam logic [PW-1:0] SPAN     = PW'(MAX_PULSE - MIN_PULSE);

   // Reject parameter sets that cannot produce a meaningful waveform.
   if (CHANNELS < 1 || MIN_PULSE >= MAX_PULSE || MAX_PULSE > PERIOD_CYCLES ||
       SLEW_STEP < 1 || PERIOD_CYCLES < 2) begin : g_bad_params
      $error("servo_pwm_multi: inconsistent parameter set");
   end

   logic [W-1:0] cnt_reg;
   logic [W-1:0] target_w_reg [CHANNELS];
   logic [W-1:0] active_w_reg [CHANNELS];
   logic [W-1:0] active_next  [CHANNELS];
   logic [CHANNELS-1:0] pwm_next;
   logic         boundary;

   // Position-to-width conversion: full-width product, then drop POS_W bits.
   logic [PW-1:0] prod;
   logic [W-1:0]  wr_width;
   assign prod     = SPAN * PW'(wr_pos);
   assign wr_width = MIN_W + W'(prod >> POS_W);

   // Last cycle of an enabled period: active widths are refreshed here.
   assign boundary = en && (cnt_reg == LAST_CNT);

   // Per-channel next active width and comparators.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
`ifdef SERVO_PWM_SLEW_EN
      localparam logic signed [W:0] STEP_POS = (W+1)'(SLEW_STEP);
      localparam logic signed [W:0] STEP_NEG = -STEP_POS;
      logic signed [W:0] diff;
      logic signed [W:0] step;
      logic signed [W:0] sum;
      // Signed distance to target, clamped to +/- SLEW_STEP.
      assign diff = $signed({1'b0, target_w_reg[gi]}) - $signed({1'b0, active_w_reg[gi]});
      assign step = (diff > STEP_POS) ? STEP_POS :
                    (diff < STEP_NEG) ? STEP_NEG : diff;
      assign sum  = $signed({1'b0, active_w_reg[gi]}) + step;
      assign active_next[gi] = sum[W-1:0];
`else
      // No slew limit: jump straight to the target.
      assign active_next[gi] = target_w_reg[gi];
`endif
      assign pwm_next[gi] = en && (cnt_reg < active_w_reg[gi]);
      assign settled[gi]  = (active_w_reg[gi] == target_w_reg[gi]);
   end

   // Shared period counter; held at zero while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (!en) begin
         cnt_reg <= '0;
      end else if (cnt_reg == LAST_CNT) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + W'(1);
      end
   end

   // Target widths take writes at any time; out-of-range channels never match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            target_w_reg[ch] <= CENTER_W;
         end
      end else if (wr_en) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            if (wr_ch == CH_W'(ch)) begin
               target_w_reg[ch] <= wr_width;
            end
         end
      end
   end

   // Active widths change only at the boundary, using pre-write targets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            active_w_reg[ch] <= CENTER_W;
         end
      end else if (boundary) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            active_w_reg[ch] <= active_next[ch];
         end
      end
   end

   // Registered outputs, one cycle behind the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_out      <= '0;
         period_start <= 1'b0;
      end else begin
         pwm_out      <= pwm_next;
         period_start <= en && (cnt_reg == '0);
      end
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Testbench for servo_pwm_multi with a shortened period. A reference model in
// plain integer arithmetic predicts every output each cycle; directed steps
// measure whole-period pulse widths against hand-derived constants.
// Honors SERVO_PWM_SLEW_EN the same way the design does.
module tb_servo_pwm_multi;

   localparam int CH   = 3;
   localparam int P    = 200;
   localparam int MINP = 25;
   localparam int MAXP = 125;
   localparam int PW   = 8;
   localparam int STEP = 10;
   localparam int CHW  = 2;
   localparam int CENTER = 75;
`ifdef SERVO_PWM_SLEW_EN
   localparam int W1_NEXT = 65;
   localparam int W2_NEXT = 85;
`else
   localparam int W1_NEXT = 25;
   localparam int W2_NEXT = 124;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic           wr_en;
   logic [CHW-1:0] wr_ch;
   logic [PW-1:0]  wr_pos;
   logic [CH-1:0]  pwm_out;
   logic           period_start;
   logic [CH-1:0]  settled;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int tgt [CH];
   int act [CH];
   int phase;
   logic [CH-1:0] exp_pwm;
   logic          exp_ps;

   servo_pwm_multi #(
      .CHANNELS(CH), .PERIOD_CYCLES(P), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
      .POS_W(PW), .SLEW_STEP(STEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_pos(wr_pos), .pwm_out(pwm_out), .period_start(period_start),
      .settled(settled)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h phase=%0d", tag, obs, exp, phase);
      end
   endtask

   function automatic int conv(input int pos);
      return MINP + (((MAXP - MINP) * pos) >> PW);
   endfunction

   function automatic int slew(input int a, input int t);
`ifdef SERVO_PWM_SLEW_EN
      int d;
      d = t - a;
      if (d > STEP) d = STEP;
      if (d < -STEP) d = -STEP;
      return a + d;
`else
      return t;
`endif
   endfunction

   function automatic logic [CH-1:0] exp_settled();
      logic [CH-1:0] s;
      for (int c = 0; c < CH; c++) s[c] = (act[c] == tgt[c]);
      return s;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         tgt[c] = CENTER;
         act[c] = CENTER;
      end
      phase   = 0;
      exp_pwm = '0;
      exp_ps  = 1'b0;
   endtask

   // Advance the model across one clock edge, then compare after the edge.
   task automatic tick();
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int c = 0; c < CH; c++) exp_pwm[c] = en && (phase < act[c]);
         exp_ps = en && (phase == 0);
         if (en && phase == P - 1)
            for (int c = 0; c < CH; c++) act[c] = slew(act[c], tgt[c]);
         if (wr_en && int'(wr_ch) < CH) tgt[wr_ch] = conv(int'(wr_pos));
         phase = en ? (phase + 1) % P : 0;
      end
      @(posedge clk);
      #1;
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("period_start", 32'(period_start), 32'(exp_ps));
      check("settled", 32'(settled), 32'(exp_settled()));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 2 * P && phase != p; i++) tick();
   endtask

   task automatic write(input int ch, input int pos);
      wr_en  = 1'b1;
      wr_ch  = CHW'(ch);
      wr_pos = PW'(pos);
      tick();
      wr_en  = 1'b0;
      $display("write ch=%0d pos=%0d phase_after=%0d", ch, pos, phase);
   endtask

   // Count high samples of one channel over the next full period.
   task automatic measure(input int ch, input int exp_w, input string tag);
      int hi;
      int guard;
      hi = 0;
      guard = 0;
      while (period_start !== 1'b1 && guard < 2 * P + 2) begin
         tick();
         guard++;
      end
      check({tag, "_ps_seen"}, 32'(period_start), 32'd1);
      for (int n = 0; n < P; n++) begin
         hi += int'(pwm_out[ch]);
         if (n < P - 1) tick();
      end
      check(tag, 32'(hi), 32'(exp_w));
      $display("measure %s ch=%0d width=%0d expected=%0d", tag, ch, hi, exp_w);
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      wr_en  = 1'b0;
      wr_ch  = '0;
      wr_pos = '0;
      model_reset();

      // Reset state.
      run(3);
      check("reset_settled", 32'(settled), 32'b111);
      rst_n = 1'b1;
      en    = 1'b1;

      // Default widths from reset.
      tick();
      check("first_period_start", 32'(period_start), 32'd1);
      measure(0, CENTER, "default_ch0");
      measure(2, CENTER, "default_ch2");

      // Mid-period write to ch1.
      wait_phase(100);
      write(1, 0);
      check("ch1_unsettled", 32'(settled[1]), 32'd0);
      measure(1, W1_NEXT, "ch1_after_write");

      // Write ch2 on the boundary edge.
      wait_phase(P - 1);
      write(2, 255);
      measure(2, CENTER, "ch2_boundary_old");
      measure(2, W2_NEXT, "ch2_boundary_new");

      // Drop enable during a pulse, then re-enable.
      wait_phase(10);
      en = 1'b0;
      tick();
      check("en_drop_pwm", 32'(pwm_out), 32'd0);
      run(4);
      en = 1'b1;
      tick();
      check("reenable_ps", 32'(period_start), 32'd1);
      measure(0, CENTER, "ch0_reenable");

      // Let any slew finish, then an out-of-range write must change nothing.
      run(12 * P);
      check("all_settled", 32'(settled), 32'b111);
      write(3, 0);
      check("oor_settled", 32'(settled), 32'b111);
      measure(0, CENTER, "ch0_after_oor");
      measure(1, 25, "ch1_final");
      measure(2, 124, "ch2_final");

      // Randomized writes, gaps and enable drops against the model.
      for (int it = 0; it < 40; it++) begin
         run($urandom_range(0, P / 2));
         write($urandom_range(0, 3), $urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) begin
            en = 1'b0;
            run($urandom_range(1, 20));
            en = 1'b1;
         end
      end
      run(12 * P);
      check("random_settled", 32'(settled), 32'b111);

      // Asynchronous reset mid-pulse.
      wait_phase(20);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_pwm", 32'(pwm_out), 32'd0);
      check("async_rst_ps", 32'(period_start), 32'd0);
      check("async_rst_settled", 32'(settled), 32'b111);
      run(3);
      rst_n = 1'b1;
      measure(0, CENTER, "post_rst_ch0");
      measure(1, CENTER, "post_rst_ch1");
      measure(2, CENTER, "post_rst_ch2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
